sap1_loader: RTL and testbench

Program loader that sits directly upstream of the SAP-1 core in the heiChips tile. It takes bytes strobed in on asynchronous pad inputs and writes them into the core's 16x8 program memory. It holds the core in reset while loading and releases it afterwards. If no load is requested at power-up, it releases the core straight away so it runs the existing memory contents.

---
 rtl/sap1_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_sap1_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sap1_loader.sv
// ---------------------------------------------------------------------------
// sap1_loader
//
// Program loader sitting in front of the SAP-1 core.
//
// A host strobes bytes in on asynchronous pad pins. The loader writes them
// into the core's program memory one word at a time, starting at address 0.
// The core is held in reset while loading is in progress. If no load is
// requested when reset is released, the core is released straight away and
// runs whatever the memory already holds.
//
// Parameters
//   ADDR_W       memory address width (memory holds 2**ADDR_W words)
//   DATA_W       memory word width
//   SYNC_STAGES  flip-flops per pad synchronizer (must be >= 2)
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   synchronous active-high reset
//   LOAD_EN   in   async pad level, 1 requests load mode
//   DSTB      in   async pad strobe, rising edge captures DIN
//   DIN       in   async pad data word
//   MEM_WE    out  one-cycle memory write enable
//   MEM_ADDR  out  memory write address
//   MEM_DIN   out  memory write data
//   CPU_RST   out  active-high reset to the core (registered)
//   LOADING   out  high while a load is in progress
//   DONE      out  high in RUN only after a complete load
// ---------------------------------------------------------------------------
module sap1_loader #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD_EN,
  input  logic              DSTB,
  input  logic [DATA_W-1:0] DIN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DIN,
  output logic              CPU_RST,
  output logic              LOADING,
  output logic              DONE
);

  localparam int                CNT_W     = $clog2(SYNC_STAGES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  // -------------------------------------------------------------------------
  // Pad synchronizers
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] load_sync_reg;
  logic [SYNC_STAGES-1:0] load_sync_next;
  logic [SYNC_STAGES-1:0] dstb_sync_reg;
  logic [SYNC_STAGES-1:0] dstb_sync_next;
  logic [DATA_W-1:0]      din_pipe_reg  [SYNC_STAGES];
  logic [DATA_W-1:0]      din_pipe_next [SYNC_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign load_sync_next[gi] = LOAD_EN;
        assign dstb_sync_next[gi] = DSTB;
        assign din_pipe_next[gi]  = DIN;
      end else begin : g_rest
        assign load_sync_next[gi] = load_sync_reg[gi-1];
        assign dstb_sync_next[gi] = dstb_sync_reg[gi-1];
        assign din_pipe_next[gi]  = din_pipe_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      load_sync_reg <= '0;
      dstb_sync_reg <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        din_pipe_reg[i] <= '0;
      end
    end else begin
      load_sync_reg <= load_sync_next;
      dstb_sync_reg <= dstb_sync_next;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        din_pipe_reg[i] <= din_pipe_next[i];
      end
    end
  end

  logic load_s;
  logic dstb_s;
  assign load_s = load_sync_reg[SYNC_STAGES-1];
  assign dstb_s = dstb_sync_reg[SYNC_STAGES-1];

  // Edge detection. The strobe edge is registered, and the data word is
  // registered alongside it, so the captured word is the one that was on
  // the pad when the strobe was first sampled high.
  logic              dstb_prev_reg;
  logic              stb_rise_reg;
  logic [DATA_W-1:0] din_aligned_reg;
  logic              load_prev_reg;
  logic              load_rise;

  always_ff @(posedge CLK) begin
    if (RST) begin
      dstb_prev_reg   <= 1'b0;
      stb_rise_reg    <= 1'b0;
      din_aligned_reg <= '0;
      load_prev_reg   <= 1'b0;
    end else begin
      dstb_prev_reg   <= dstb_s;
      stb_rise_reg    <= dstb_s & ~dstb_prev_reg;
      din_aligned_reg <= din_pipe_reg[SYNC_STAGES-1];
      load_prev_reg   <= load_s;
    end
  end

  // load_prev_reg tracks the level continuously, so a LOAD_EN that is
  // already high when RUN is entered never looks like a fresh request.
  assign load_rise = load_s & ~load_prev_reg;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RUN
  } state_t;

  state_t            state_reg,    state_next;
  logic [ADDR_W-1:0] addr_reg,     addr_next;
  logic [CNT_W-1:0]  settle_reg,   settle_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_din_reg,  mem_din_next;
  logic              mem_we_reg,   mem_we_next;
  logic              cpu_rst_reg,  cpu_rst_next;
  logic              loading_reg,  loading_next;
  logic              done_reg,     done_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      settle_reg   <= '0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      mem_we_reg   <= 1'b0;
      cpu_rst_reg  <= 1'b1;
      loading_reg  <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      settle_reg   <= settle_next;
      mem_addr_reg <= mem_addr_next;
      mem_din_reg  <= mem_din_next;
      mem_we_reg   <= mem_we_next;
      cpu_rst_reg  <= cpu_rst_next;
      loading_reg  <= loading_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    settle_next   = settle_reg;
    mem_addr_next = mem_addr_reg;
    mem_din_next  = mem_din_reg;
    done_next     = done_reg;

    case (state_reg)
      S_IDLE: begin
        // Wait long enough for the LOAD_EN synchronizer to fill with the
        // real pad level before deciding what to do.
        if (settle_reg == CNT_W'(SYNC_STAGES)) begin
          if (load_s) begin
            state_next = S_LOAD;
            addr_next  = '0;
          end else begin
            state_next = S_RUN;
          end
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end

      S_LOAD: begin
        // A strobe wins over a falling LOAD_EN in the same cycle so that
        // the host's last byte is not dropped.
        if (stb_rise_reg) begin
          state_next    = S_WRITE;
          mem_addr_next = addr_reg;
          mem_din_next  = din_aligned_reg;
        end else if (!load_s) begin
          state_next = S_RUN;
          done_next  = 1'b0;
        end
      end

      S_WRITE: begin
        if (addr_reg == LAST_ADDR) begin
          state_next = S_RUN;
          done_next  = 1'b1;
        end else begin
          state_next = S_LOAD;
          addr_next  = addr_reg + 1'b1;
        end
      end

      S_RUN: begin
        if (load_rise) begin
          state_next = S_LOAD;
          addr_next  = '0;
          done_next  = 1'b0;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they change on the
    // same edge that enters the state they belong to.
    mem_we_next  = (state_next == S_WRITE);
    cpu_rst_next = (state_next != S_RUN);
    loading_next = (state_next == S_LOAD) || (state_next == S_WRITE);
  end

  assign MEM_WE   = mem_we_reg;
  assign MEM_ADDR = mem_addr_reg;
  assign MEM_DIN  = mem_din_reg;
  assign CPU_RST  = cpu_rst_reg;
  assign LOADING  = loading_reg;
  assign DONE     = done_reg;

endmodule

// File: tb/tb_sap1_loader.sv
// ---------------------------------------------------------------------------
// tb_sap1_loader
//
// Directed bench for sap1_loader with default parameters (16 x 8 memory,
// two-stage synchronizers). A negedge monitor logs every write pulse with
// its address, data and cycle number; directed sequences then compare the
// log and the status outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_sap1_loader;

  logic       clk;
  logic       rst;
  logic       load_en;
  logic       dstb;
  logic [7:0] din;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic       cpu_rst;
  logic       loading;
  logic       done;

  sap1_loader #(
    .ADDR_W     (4),
    .DATA_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .LOAD_EN (load_en),
    .DSTB    (dstb),
    .DIN     (din),
    .MEM_WE  (mem_we),
    .MEM_ADDR(mem_addr),
    .MEM_DIN (mem_din),
    .CPU_RST (cpu_rst),
    .LOADING (loading),
    .DONE    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Write log
  logic [3:0] wr_addr [$];
  logic [7:0] wr_data [$];
  int         wr_cyc  [$];
  int         wide_cnt = 0;
  logic       we_prev  = 1'b0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_din);
      wr_cyc.push_back(cyc);
      $display("[%0t] write addr=%0d data=%02h", $time, mem_addr, mem_din);
    end
    if (mem_we === 1'b1 && we_prev === 1'b1) wide_cnt++;
    we_prev = mem_we;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance n cycles; returns 2 ns after a falling edge, after the monitor.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Data is set at the start of the low phase and held until DSTB falls.
  task automatic strobe(input logic [7:0] d, input int hi, input int lo);
    din  = d;
    tick(lo);
    dstb = 1'b1;
    tick(hi);
    dstb = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_we"},      {31'd0, mem_we},  32'd0);
    check_eq({pfx, "_addr"},    {28'd0, mem_addr}, 32'd0);
    check_eq({pfx, "_din"},     {24'd0, mem_din}, 32'd0);
    check_eq({pfx, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    check_eq({pfx, "_loading"}, {31'd0, loading}, 32'd0);
    check_eq({pfx, "_done"},    {31'd0, done},    32'd0);
  endtask

  task automatic check_log(input string pfx, input int first_idx,
                           input int count, input int first_addr,
                           input logic [7:0] first_data);
    for (int i = 0; i < count; i++) begin
      if (first_idx + i < wr_addr.size()) begin
        check_eq($sformatf("%s_addr%0d", pfx, i),
                 {28'd0, wr_addr[first_idx+i]}, 32'(first_addr + i));
        check_eq($sformatf("%s_data%0d", pfx, i),
                 {24'd0, wr_data[first_idx+i]}, 32'(first_data) + 32'(i));
      end
    end
  endtask

  initial begin
    int rise_cyc;
    int n;
    bit found;

    rst     = 1'b1;
    load_en = 1'b0;
    dstb    = 1'b0;
    din     = 8'h00;

    // ---------------- reset state, then no load requested ----------------
    tick(2);
    check_reset_outputs("rst");
    rst = 1'b0;
    tick(1);
    check_eq("noload_cpu_rst_c2", {31'd0, cpu_rst}, 32'd1);
    tick(1);
    check_eq("noload_cpu_rst_c3", {31'd0, cpu_rst}, 32'd1);
    tick(1);
    check_eq("noload_cpu_rst_run", {31'd0, cpu_rst}, 32'd0);
    check_eq("noload_loading",     {31'd0, loading}, 32'd0);
    check_eq("noload_done",        {31'd0, done},    32'd0);
    strobe(8'hEE, 2, 3);
    tick(6);
    check_eq("noload_writes", 32'(wr_addr.size()), 32'd0);

    // ---------------- full load ----------------
    load_en = 1'b1;
    pulse_reset();
    tick(3);
    check_eq("full_loading", {31'd0, loading}, 32'd1);
    check_eq("full_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    clear_log();
    for (int i = 0; i < 16; i++) strobe(8'h10 + 8'(i), 2, 3);
    tick(4);
    check_eq("full_count", 32'(wr_addr.size()), 32'd16);
    check_log("full", 0, 16, 0, 8'h10);
    check_eq("full_cpu_rst_end", {31'd0, cpu_rst}, 32'd0);
    check_eq("full_done",        {31'd0, done},    32'd1);
    check_eq("full_loading_end", {31'd0, loading}, 32'd0);
    check_eq("full_addr_hold",   {28'd0, mem_addr}, 32'd15);
    check_eq("full_din_hold",    {24'd0, mem_din}, 32'h1F);
    strobe(8'h55, 2, 3);
    tick(6);
    check_eq("full_17th_ignored", 32'(wr_addr.size()), 32'd16);
    check_eq("full_no_retrigger", {31'd0, cpu_rst}, 32'd0);

    // ---------------- reload from RUN, then abort ----------------
    load_en = 1'b0;
    tick(4);
    check_eq("reload_done_kept", {31'd0, done}, 32'd1);
    load_en = 1'b1;
    tick(4);
    check_eq("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check_eq("reload_done",    {31'd0, done},    32'd0);
    check_eq("reload_loading", {31'd0, loading}, 32'd1);
    clear_log();
    for (int i = 0; i < 5; i++) strobe(8'hA0 + 8'(i), 2, 3);
    tick(4);
    load_en = 1'b0;
    tick(5);
    check_eq("abort_count",   32'(wr_addr.size()), 32'd5);
    check_log("abort", 0, 5, 0, 8'hA0);
    check_eq("abort_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check_eq("abort_done",    {31'd0, done},    32'd0);
    check_eq("abort_loading", {31'd0, loading}, 32'd0);

    // ---------------- reset during WRITE at address 7 ----------------
    load_en = 1'b1;
    tick(5);
    clear_log();
    for (int i = 0; i < 7; i++) strobe(8'h30 + 8'(i), 2, 3);
    tick(4);
    din = 8'h77;
    tick(3);
    dstb  = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick(1);
      if (mem_we === 1'b1) found = 1'b1;
    end
    check_eq("midrst_we_seen", {31'd0, found}, 32'd1);
    check_eq("midrst_write_addr", {28'd0, mem_addr}, 32'd7);
    check_eq("midrst_write_data", {24'd0, mem_din},  32'h77);
    rst  = 1'b1;
    dstb = 1'b0;
    tick(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    n = wr_addr.size();
    check_eq("midrst_count", 32'(n), 32'd8);
    tick(3);
    check_eq("midrst_reload", {31'd0, loading}, 32'd1);
    tick(4);
    check_eq("midrst_no_write", 32'(wr_addr.size()), 32'(n));
    strobe(8'h99, 2, 3);
    tick(4);
    check_eq("midrst_next_count", 32'(wr_addr.size()), 32'(n + 1));
    check_log("midrst_next", n, 1, 0, 8'h99);

    // ---------------- latency and 2/2 strobes ----------------
    pulse_reset();
    tick(3);
    clear_log();
    din = 8'h5A;
    tick(3);
    dstb     = 1'b1;
    rise_cyc = cyc;
    tick(2);
    dstb = 1'b0;
    tick(4);
    check_eq("lat_count", 32'(wr_addr.size()), 32'd1);
    if (wr_cyc.size() > 0)
      check_eq("lat_edges", 32'(wr_cyc[0] - rise_cyc), 32'd4);
    check_log("lat", 0, 1, 0, 8'h5A);
    for (int i = 0; i < 6; i++) strobe(8'hC0 + 8'(i), 2, 2);
    tick(4);
    check_eq("b2b_count", 32'(wr_addr.size()), 32'd7);
    check_log("b2b", 1, 6, 1, 8'hC0);
    check_eq("we_single_cycle", 32'(wide_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
